// File: rtl/dot_seq_pkg.sv
// rtl/dot_seq_pkg.sv - shared types and widths for the dot-product sequencer
// Purpose: FSM state encoding, datapath widths shared with the macc, and the
//          ReLU helper used when DOT_SEQ_RELU_EN is defined.
// Ports:   none (package).
package dot_seq_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] x);
    return x[ACC_WIDTH-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/dot_seq_ctrl.sv
// rtl/dot_seq_ctrl.sv - sequencer driving one macc through a full dot product
// Purpose: on start, clears the macc, streams len element pairs from two
//          1-cycle-latency read ports into it, waits for the final accumulate
//          and presents the result on a valid/ready output.
// Macro:   DOT_SEQ_RELU_EN - when defined, res_data is clamped at zero (ReLU).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, len, a_base, b_base    request from the layer scheduler (IDLE only)
//   abort                         synchronous cancel of the current operation
//   busy                          high whenever the FSM is not IDLE
//   a_rd_en/a_rd_addr/a_rd_data   vector A read port (data 1 cycle after en)
//   b_rd_en/b_rd_addr/b_rd_data   vector B read port (data 1 cycle after en)
//   mac_in_valid, mac_a, mac_b    element pair towards the macc
//   mac_clear, mac_acc            macc accumulator clear / current value
//   res_valid, res_ready, res_data  result handshake
module dot_seq_ctrl
  import dot_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic [ADDR_WIDTH-1:0]        a_base,
  input  logic [ADDR_WIDTH-1:0]        b_base,
  input  logic                         abort,
  output logic                         busy,
  output logic                         a_rd_en,
  output logic [ADDR_WIDTH-1:0]        a_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] a_rd_data,
  output logic                         b_rd_en,
  output logic [ADDR_WIDTH-1:0]        b_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] b_rd_data,
  output logic                         mac_in_valid,
  output logic signed [DATA_WIDTH-1:0] mac_a,
  output logic signed [DATA_WIDTH-1:0] mac_b,
  output logic                         mac_clear,
  input  logic signed [ACC_WIDTH-1:0]  mac_acc,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [ACC_WIDTH-1:0]  res_data
);

  state_e                  state_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    idx_q;
  logic [ADDR_WIDTH-1:0]   a_base_q;
  logic [ADDR_WIDTH-1:0]   b_base_q;
  logic [ADDR_WIDTH-1:0]   a_addr_q;
  logic [ADDR_WIDTH-1:0]   b_addr_q;
  logic                    rd_en_q;
  logic                    mac_in_valid_q;
  logic                    mac_clear_q;
  logic                    res_valid_q;

  logic [ADDR_WIDTH-1:0]   a_addr_d;
  logic [ADDR_WIDTH-1:0]   b_addr_d;
  logic                    last_issue_d;
  logic signed [ACC_WIDTH-1:0] res_acc_d;

  // Address sums wrap naturally at ADDR_WIDTH.
  assign a_addr_d     = a_base_q + ADDR_WIDTH'(idx_q);
  assign b_addr_d     = b_base_q + ADDR_WIDTH'(idx_q);
  assign last_issue_d = (idx_q == len_q - LEN_WIDTH'(1));

  // All strobes are registered, so each one appears on the port in the cycle
  // after the state that decides it: mac_clear follows CLEAR, a read issued
  // in the last STREAM cycle is on the port during DRAIN, its data reaches the
  // macc in the first DONE cycle and res_valid rises once that accumulate has
  // landed in mac_acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
      a_addr_q       <= '0;
      b_addr_q       <= '0;
      rd_en_q        <= 1'b0;
      mac_in_valid_q <= 1'b0;
      mac_clear_q    <= 1'b0;
      res_valid_q    <= 1'b0;
    end else if (abort && (state_q != IDLE)) begin
      // Abort wins over everything, including a DONE handshake; the pipe
      // flag is dropped so the macc sees no further element.
      state_q        <= IDLE;
      rd_en_q        <= 1'b0;
      mac_in_valid_q <= 1'b0;
      mac_clear_q    <= 1'b0;
      res_valid_q    <= 1'b0;
    end else begin
      mac_in_valid_q <= rd_en_q;
      rd_en_q        <= 1'b0;
      mac_clear_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            a_base_q <= a_base;
            b_base_q <= b_base;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clear_q <= 1'b1;
          idx_q       <= '0;
          state_q     <= (len_q == '0) ? DONE : STREAM;
        end
        STREAM: begin
          rd_en_q  <= 1'b1;
          a_addr_q <= a_addr_d;
          b_addr_q <= b_addr_d;
          idx_q    <= idx_q + LEN_WIDTH'(1);
          if (last_issue_d) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle lets the final accumulate settle; then the
          // result is offered and held until accepted.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
          end else if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DOT_SEQ_RELU_EN
  assign res_acc_d = relu(mac_acc);
`else
  assign res_acc_d = mac_acc;
`endif

  // mac_acc is stable while res_valid is high, so passing it through keeps
  // res_data stable for the whole handshake.
  assign res_data     = res_valid_q ? res_acc_d : '0;
  assign res_valid    = res_valid_q;
  assign busy         = (state_q != IDLE);
  assign a_rd_en      = rd_en_q;
  assign b_rd_en      = rd_en_q;
  assign a_rd_addr    = a_addr_q;
  assign b_rd_addr    = b_addr_q;
  assign mac_in_valid = mac_in_valid_q;
  assign mac_clear    = mac_clear_q;
  assign mac_a        = a_rd_data;
  assign mac_b        = b_rd_data;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// tb/tb_dot_seq_ctrl.sv - self-checking bench for dot_seq_ctrl with SRAM and macc models
module tb_dot_seq_ctrl;
  import dot_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [9:0] len = '0;
  logic [9:0] a_base = '0;
  logic [9:0] b_base = '0;
  logic abort = 1'b0;
  logic busy;
  logic a_rd_en, b_rd_en;
  logic [9:0] a_rd_addr, b_rd_addr;
  logic signed [DATA_WIDTH-1:0] a_rd_data, b_rd_data;
  logic mac_in_valid, mac_clear;
  logic signed [DATA_WIDTH-1:0] mac_a, mac_b;
  logic signed [ACC_WIDTH-1:0] mac_acc;
  logic res_valid;
  logic res_ready = 1'b1;
  logic signed [ACC_WIDTH-1:0] res_data;

  logic signed [DATA_WIDTH-1:0] mem_a [0:1023];
  logic signed [DATA_WIDTH-1:0] mem_b [0:1023];
  logic [9:0] a_log [0:255];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int miv_cnt = 0;
  int clr_cnt = 0;
  int rv_cnt = 0;

  dot_seq_ctrl #(.ADDR_WIDTH(10), .LEN_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .a_base(a_base),
    .b_base(b_base), .abort(abort), .busy(busy),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .mac_in_valid(mac_in_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_clear(mac_clear), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency SRAMs
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  // macc environment model
  always @(posedge clk or posedge rst) begin
    if (rst) mac_acc <= '0;
    else if (mac_clear) mac_acc <= '0;
    else if (mac_in_valid) mac_acc <= mac_acc + (32'(mac_a) * 32'(mac_b));
  end

  always @(negedge clk) begin
    if (a_rd_en) begin
      a_log[rd_cnt[7:0]] = a_rd_addr;
      rd_cnt = rd_cnt + 1;
    end
    if (mac_in_valid) miv_cnt = miv_cnt + 1;
    if (mac_clear) clr_cnt = clr_cnt + 1;
    if (res_valid) rv_cnt = rv_cnt + 1;
  end

  task automatic run_op(input int l, input int ab, input int bb, input int exp_lat,
                        input logic signed [31:0] exp_data, input string name);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; len = 10'(l); a_base = 10'(ab); b_base = 10'(bb);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (res_valid) got = 1;
    end
    checks++;
    if (!got || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, lat, got, exp_lat);
    end
    checks++;
    if (res_data !== exp_data) begin
      errors++;
      $display("FAIL %s res_data: got %0d expected %0d", name, res_data, exp_data);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, a_rd_en, b_rd_en, mac_in_valid, mac_clear, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset strobes: got %b expected 000000",
               {busy, a_rd_en, b_rd_en, mac_in_valid, mac_clear, res_valid});
    end
    checks++;
    if ({a_rd_addr, b_rd_addr} !== 20'd0 || res_data !== 32'sd0) begin
      errors++;
      $display("FAIL reset data: addr %0d/%0d res %0d expected 0", a_rd_addr, b_rd_addr, res_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int c0, m0;
    c0 = clr_cnt; m0 = miv_cnt;
    res_ready = 1'b1;
    run_op(3, 0, 100, 6, 32'sd32, "basic");
    @(posedge clk); #1;
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL basic clear pulses: got %0d expected 1", clr_cnt - c0);
    end
    checks++;
    if (miv_cnt - m0 != 3) begin
      errors++;
      $display("FAIL basic mac_in_valid cycles: got %0d expected 3", miv_cnt - m0);
    end
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic post-handshake: busy %b res_valid %b expected 0 0", busy, res_valid);
    end
  endtask

  task automatic test_len0();
    int c0, r0;
    c0 = clr_cnt; r0 = rd_cnt;
    run_op(0, 0, 100, 2, 32'sd0, "len0");
    @(posedge clk); #1;
    checks++;
    if (clr_cnt - c0 != 1 || rd_cnt - r0 != 0) begin
      errors++;
      $display("FAIL len0 strobes: clear %0d rd %0d expected 1 0", clr_cnt - c0, rd_cnt - r0);
    end
  endtask

  task automatic test_hold();
    logic signed [31:0] exp_v;
`ifdef DOT_SEQ_RELU_EN
    exp_v = 32'sd0;
`else
    exp_v = -32'sd13;
`endif
    res_ready = 1'b0;
    run_op(2, 10, 110, 5, exp_v, "hold");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_v) begin
        errors++;
        $display("FAIL hold stable[%0d]: valid %b data %0d expected 1 %0d", i, res_valid, res_data, exp_v);
      end
      if (i == 1) begin
        start = 1'b1; len = 10'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold release: valid %b busy %b expected 0 0", res_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done start ignored: busy %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int r0, m0, v0;
    @(negedge clk);
    start = 1'b1; len = 10'd8; a_base = 10'd0; b_base = 10'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, a_rd_en, b_rd_en, mac_in_valid} !== 4'b0) begin
      errors++;
      $display("FAIL abort idle: busy/rd/rd/miv %b expected 0000", {busy, a_rd_en, b_rd_en, mac_in_valid});
    end
    r0 = rd_cnt; m0 = miv_cnt; v0 = rv_cnt;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt != r0 || miv_cnt != m0 || rv_cnt != v0) begin
      errors++;
      $display("FAIL abort quiet: rd %0d miv %0d rv %0d expected 0 0 0", rd_cnt - r0, miv_cnt - m0, rv_cnt - v0);
    end
    run_op(1, 300, 400, 4, 32'sd49, "after_abort");
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int r0;
    r0 = rd_cnt;
    run_op(2, 1023, 500, 5, 32'sd10, "wrap");
    @(posedge clk); #1;
    checks++;
    if (rd_cnt - r0 != 2 || a_log[r0[7:0]] !== 10'd1023 || a_log[8'(r0 + 1)] !== 10'd0) begin
      errors++;
      $display("FAIL wrap addrs: n %0d first %0d second %0d expected 2 1023 0",
               rd_cnt - r0, a_log[r0[7:0]], a_log[8'(r0 + 1)]);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; len = 10'd8; a_base = 10'd0; b_base = 10'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, a_rd_en, b_rd_en, mac_in_valid, mac_clear, res_valid} !== 6'b0 ||
        a_rd_addr !== 10'd0 || b_rd_addr !== 10'd0 || res_data !== 32'sd0) begin
      errors++;
      $display("FAIL mid reset: strobes %b addr %0d/%0d expected all 0",
               {busy, a_rd_en, b_rd_en, mac_in_valid, mac_clear, res_valid}, a_rd_addr, b_rd_addr);
    end
    @(negedge clk); rst = 1'b0;
    run_op(1, 300, 400, 4, 32'sd49, "b2b_first");
    @(posedge clk); #1;
    run_op(3, 0, 100, 6, 32'sd32, "b2b_second");
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 16'sd1;  mem_a[1] = 16'sd2;  mem_a[2] = 16'sd3;
    mem_b[100] = 16'sd4; mem_b[101] = 16'sd5; mem_b[102] = 16'sd6;
    mem_a[10] = -16'sd3; mem_a[11] = 16'sd2;
    mem_b[110] = 16'sd5; mem_b[111] = 16'sd1;
    mem_a[300] = 16'sd7; mem_b[400] = 16'sd7;
    mem_a[1023] = 16'sd3;
    mem_b[500] = 16'sd4; mem_b[501] = -16'sd2;
    test_reset();
    test_basic();
    test_len0();
    test_hold();
    test_abort();
    test_wrap();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_seq_ctrl.md
Name: dot_seq_ctrl

Overview:
- Sequencer driving one macc instance through a full dot product.
- On start: clears the accumulator, streams len element pairs from two 1-cycle-latency read ports (vector A, vector B) into the MAC, waits for the final accumulate, then presents the result on a valid/ready output.
- Sits between the layer scheduler (start/len/base) and the MAC datapath plus weight/activation SRAMs.

Parameters:
- ADDR_WIDTH, 10, SRAM address width for both read ports.
- LEN_WIDTH, 10, width of the vector length field; max len = 2^LEN_WIDTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request new dot product; accepted only in IDLE
- len  input  LEN_WIDTH  element count, sampled on accept
- a_base  input  ADDR_WIDTH  vector A start address, sampled on accept
- b_base  input  ADDR_WIDTH  vector B start address, sampled on accept
- abort  input  1  synchronous cancel of the current operation
- busy  output  1  high in any state other than IDLE
- a_rd_en  output  1  read strobe, port A
- a_rd_addr  output  ADDR_WIDTH  read address, port A
- a_rd_data  input  DATA_WIDTH  signed read data, valid 1 cycle after a_rd_en
- b_rd_en  output  1  read strobe, port B
- b_rd_addr  output  ADDR_WIDTH  read address, port B
- b_rd_data  input  DATA_WIDTH  signed read data, valid 1 cycle after b_rd_en
- mac_in_valid  output  1  to macc in_valid
- mac_a  output  DATA_WIDTH  to macc a (= a_rd_data)
- mac_b  output  DATA_WIDTH  to macc b (= b_rd_data)
- mac_clear  output  1  to macc acc_clear
- mac_acc  input  ACC_WIDTH  from macc acc
- res_valid  output  1  result valid
- res_ready  input  1  result consumer ready
- res_data  output  ACC_WIDTH  signed result

Behaviour:
- Reset (async, rst=1): state=IDLE; index counter=0. Outputs busy, a_rd_en, b_rd_en, mac_in_valid, mac_clear, res_valid = 0; addresses=0; res_data=0.
- IDLE: start=1 latches len, a_base, b_base, then -> CLEAR. start is ignored in all other states.
- CLEAR (1 cycle): mac_clear=1; idx<=0.
  - len==0 -> DONE.
  - else -> STREAM.
- STREAM:
  - Each cycle: a_rd_en = b_rd_en = 1; a_rd_addr = a_base+idx; b_rd_addr = b_base+idx; idx++.
  - After the issue with idx==len-1 -> DRAIN.
  - Address addition wraps modulo 2^ADDR_WIDTH.
- mac_in_valid is the 1-cycle-delayed rd_en (a registered pipe flag). mac_a and mac_b are combinational passthroughs of the read data.
- DRAIN (1 cycle): carries the last mac_in_valid. -> DONE.
- DONE:
  - res_valid=1 and res_data=mac_acc; both held stable until res_ready=1.
  - When res_valid & res_ready -> IDLE.
- Timing: start accepted at edge 0 -> res_valid first high len+3 cycles later. For len=0: 2 cycles later, with res_data=0.
- Accumulator overflow wraps at ACC_WIDTH (macc arithmetic); no saturation.
- abort=1 in any non-IDLE state:
  - -> IDLE next cycle.
  - In-flight mac_in_valid pipe flag is cleared; no result is produced.
  - abort has priority over every other transition, including a DONE handshake in the same cycle.
- abort in IDLE: no effect.
- Reset mid-operation: immediate return to the reset state; the macc is not cleared by this block (it has its own reset).

Optional Feature:
- Macro DOT_SEQ_RELU_EN.
- Defined: res_data = (mac_acc < 0) ? 0 : mac_acc, i.e. fused ReLU on the output.
- Undefined: res_data = mac_acc unmodified.
- Latency, handshake and all other behaviour are identical in both builds.

Decomposition:
- Shared package (dot_seq_pkg): state enum (IDLE, CLEAR, STREAM, DRAIN, DONE); DATA_WIDTH and ACC_WIDTH from the common defs header.
- No sub-module. A single FSM plus counter is natural.
- The macc is instantiated by the parent, not inside this block.

Test Plan:
- len=3, A=[1,2,3], B=[4,5,6], res_ready=1 -> res_valid 6 cycles after accept, res_data=32, mac_clear exactly 1 pulse, mac_in_valid high 3 cycles.
- len=0 -> mac_clear pulse, no rd_en, res_valid 2 cycles after accept with res_data=0.
- len=2, A=[-3,2], B=[5,1], res_ready held 0 for 4 cycles:
  - -> res_valid/res_data=-13 held stable until ready; start pulsed during DONE is ignored.
  - With DOT_SEQ_RELU_EN defined -> res_data=0.
- len=8, abort asserted on 3rd STREAM cycle -> IDLE next cycle, no further rd_en/mac_in_valid, res_valid never asserted; next start with len=1, A=[7], B=[7] -> 49.
- a_base=2^ADDR_WIDTH-1, len=2 -> addresses 1023 then 0 (wrap).
- rst asserted mid-STREAM -> all outputs 0 immediately; after release, back-to-back starts are accepted and both results are correct.
